// File: rtl/dsp48a1_mac_sequencer.sv
// Sequences one DSP48A1 slice through a sum-of-products job and returns the final P.
// A per-cycle tag pipeline tracks which DSP_A cycles carry data so OPMODE and capture line up.
module dsp48a1_mac_sequencer #(
    parameter int A_DATA_WIDTH = 18,
    parameter int B_DATA_WIDTH = 18,
    parameter int P_DATA_WIDTH = 48,
    parameter int LEN_WIDTH    = 16,
    parameter int OPMODE_LAT   = 1,
    parameter int RES_LAT      = 3
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    START,
    input  logic [LEN_WIDTH-1:0]    LEN,
    output logic                    BUSY,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [A_DATA_WIDTH-1:0] IN_A,
    input  logic [B_DATA_WIDTH-1:0] IN_B,
    output logic [A_DATA_WIDTH-1:0] DSP_A,
    output logic [B_DATA_WIDTH-1:0] DSP_B,
    output logic [7:0]              DSP_OPMODE,
    output logic                    DSP_CE,
    output logic                    DSP_RST,
    input  logic [P_DATA_WIDTH-1:0] DSP_P,
    output logic                    RES_VALID,
    input  logic                    RES_READY,
    output logic [P_DATA_WIDTH-1:0] RES_DATA
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [7:0] OPMODE_FIRST = 8'h01;
    localparam logic [7:0] OPMODE_ACCUM = 8'h09;
    localparam logic [7:0] OPMODE_HOLD  = 8'h08;

    state_t               state;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 first_pending;

    // Bit k of each tag vector describes the DSP_A value driven k cycles ago.
    logic [RES_LAT:0] tag_first;
    logic [RES_LAT:0] tag_data;
    logic [RES_LAT:0] tag_last;

    logic beat_ok;
    logic push_first;
    logic push_last;

    assign beat_ok    = (state == RUN) && IN_VALID;
    assign push_first = beat_ok && first_pending;
    assign push_last  = beat_ok && (remaining == LEN_WIDTH'(1));

    assign BUSY     = (state != IDLE);
    assign IN_READY = (state == RUN);
    assign DSP_RST  = ~RST_N;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state         <= IDLE;
            remaining     <= '0;
            first_pending <= 1'b0;
            tag_first     <= '0;
            tag_data      <= '0;
            tag_last      <= '0;
            DSP_A         <= '0;
            DSP_B         <= '0;
            DSP_OPMODE    <= 8'h00;
            DSP_CE        <= 1'b0;
            RES_VALID     <= 1'b0;
            RES_DATA      <= '0;
        end else begin
            tag_first <= {tag_first[RES_LAT-1:0], push_first};
            tag_data  <= {tag_data[RES_LAT-1:0], beat_ok};
            tag_last  <= {tag_last[RES_LAT-1:0], push_last};

            // Bubble and idle tags keep Z=P so the accumulator simply holds.
            if (tag_data[OPMODE_LAT-1]) begin
                DSP_OPMODE <= tag_first[OPMODE_LAT-1] ? OPMODE_FIRST : OPMODE_ACCUM;
            end else begin
                DSP_OPMODE <= OPMODE_HOLD;
            end

            case (state)
                IDLE: begin
                    DSP_CE <= 1'b0;
                    if (START) begin
                        if (LEN != '0) begin
                            remaining     <= LEN;
                            first_pending <= 1'b1;
                            DSP_CE        <= 1'b1;
                            state         <= RUN;
                        end else begin
                            RES_DATA  <= '0;
                            RES_VALID <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                RUN: begin
                    if (beat_ok) begin
                        DSP_A         <= IN_A;
                        DSP_B         <= IN_B;
                        remaining     <= remaining - LEN_WIDTH'(1);
                        first_pending <= 1'b0;
                        if (remaining == LEN_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end else begin
                        DSP_A <= '0;
                        DSP_B <= '0;
                    end
                end

                DRAIN: begin
                    DSP_A <= '0;
                    DSP_B <= '0;
                    if (tag_last[RES_LAT]) begin
                        RES_DATA  <= DSP_P;
                        RES_VALID <= 1'b1;
                        DSP_CE    <= 1'b0;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (RES_READY) begin
                        RES_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
